// File: rtl/alu_arbiter.sv
// Two-requester ALU with a three-state IDLE/EXEC/RESP handshake and a shared result bus.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to requester 0.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [2:0]       op_ctrl_r;
  logic             id_r;
  logic             last_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             grant0_s;
  logic             grant1_s;
  logic             rsp_done_s;
  logic [WIDTH-1:0] alu_s;

  function automatic logic [WIDTH-1:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0]       ctrl);
    logic [WIDTH-1:0] r;
    case (ctrl)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a + b;
      3'b110:  r = a - b;
      3'b111:  r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Arbitration: grants only in IDLE and only to a requester whose valid is high.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
        grant0_s = last_r;
        grant1_s = ~last_r;
`else
        grant0_s = 1'b1;
        grant1_s = 1'b0;
`endif
      end else if (req0_valid) begin
        grant0_s = 1'b1;
      end else if (req1_valid) begin
        grant1_s = 1'b1;
      end else begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Next-state logic; rspN_ready from the requester not being served never completes RESP.
  always_comb begin
    state_s    = state_r;
    rsp_done_s = 1'b0;
    alu_s      = alu_op(op_a_r, op_b_r, op_ctrl_r);
    case (state_r)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          state_s = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        rsp_done_s = id_r ? rsp1_ready : rsp0_ready;
        if (rsp_done_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand latch, result register and last-grant pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_a_r    <= {WIDTH{1'b0}};
      op_b_r    <= {WIDTH{1'b0}};
      op_ctrl_r <= 3'b000;
      id_r      <= 1'b0;
      last_r    <= 1'b1;
      result_r  <= {WIDTH{1'b0}};
      zero_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (grant0_s) begin
        op_a_r    <= req0_a;
        op_b_r    <= req0_b;
        op_ctrl_r <= req0_ctrl;
        id_r      <= 1'b0;
      end else if (grant1_s) begin
        op_a_r    <= req1_a;
        op_b_r    <= req1_b;
        op_ctrl_r <= req1_ctrl;
        id_r      <= 1'b1;
      end
      if (state_r == EXEC) begin
        result_r <= alu_s;
        zero_r   <= (alu_s == {WIDTH{1'b0}});
      end
      // Pointer is kept in both builds; only round-robin arbitration reads it.
      last_r <= rsp_done_s ? id_r : last_r;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp0_valid = (state_r == RESP) && !id_r;
  assign rsp1_valid = (state_r == RESP) && id_r;
  assign rsp_result = result_r;
  assign rsp_zero   = zero_r;
  assign busy       = (state_r != IDLE);

endmodule
